// File: rtl/lane_draw_sequencer_if.sv
// Handshake bundle between the lane draw sequencer and its environment:
// song/player controls and shape-drawer handshake in, clear-pixel stream and
// status out.
interface lane_draw_sequencer_if #(
    parameter int XY_W   = 8,
    parameter int ADDR_W = 16,
    parameter int BOX_W  = 4
) ();
    logic              start;
    logic              beat_tick;
    logic              song_done;
    logic              pause;
    logic              clear_req;
    logic              shape_done;
    logic              clear_we;
    logic [ADDR_W-1:0] clear_addr;
    logic [XY_W-1:0]   clear_x;
    logic [XY_W-1:0]   clear_y;
    logic              shape_start;
    logic [BOX_W-1:0]  box_index;
    logic              ready_for_song;
    logic              busy;
    logic              beat_overrun;
    logic [2:0]        state;

    modport slave (
        input  start, beat_tick, song_done, pause, clear_req, shape_done,
        output clear_we, clear_addr, clear_x, clear_y, shape_start, box_index,
               ready_for_song, busy, beat_overrun, state
    );

    modport master (
        output start, beat_tick, song_done, pause, clear_req, shape_done,
        input  clear_we, clear_addr, clear_x, clear_y, shape_start, box_index,
               ready_for_song, busy, beat_overrun, state
    );
endinterface

// File: rtl/lane_draw_sequencer.sv
// Lane draw sequencer: clears the pixel grid, waits for the player to press
// and release start, then on every beat asks the shape drawer to draw each
// note box in turn.
//
// state      | meaning
// -----------+---------------------------------------------------------
// CLEAR      | writing the default pixel to every grid location
// IDLE       | grid clean, waiting for start to be pressed
// START_WAIT | start pressed, waiting for release
// WAIT_BEAT  | song running, waiting for the next beat
// ISSUE      | one-cycle shape_start for box_index
// WAIT_SHAPE | waiting for shape_done of the current box
module lane_draw_sequencer #(
    parameter int GRID_W    = 240,
    parameter int GRID_H    = 180,
    parameter int NUM_BOXES = 12,
    parameter int XY_W      = 8,
    parameter int ADDR_W    = 16,
    parameter int BOX_W     = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    lane_draw_sequencer_if.slave   bus
);

    localparam logic [2:0] S_CLEAR      = 3'd0;
    localparam logic [2:0] S_IDLE       = 3'd1;
    localparam logic [2:0] S_START_WAIT = 3'd2;
    localparam logic [2:0] S_WAIT_BEAT  = 3'd3;
    localparam logic [2:0] S_ISSUE      = 3'd4;
    localparam logic [2:0] S_WAIT_SHAPE = 3'd5;

    localparam logic [XY_W-1:0]   X_LAST    = XY_W'(GRID_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(GRID_W * GRID_H - 1);
    localparam logic [BOX_W-1:0]  BOX_LAST  = BOX_W'(NUM_BOXES - 1);

    logic [2:0]        state_q, state_d;
    logic [XY_W-1:0]   x_q, x_d;
    logic [XY_W-1:0]   y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BOX_W-1:0]  box_q, box_d;
    logic              pend_q, pend_d;
    logic              ovr_q, ovr_d;
    logic              abort_ev;

    assign abort_ev = bus.song_done | bus.clear_req;

    // Next-state, clear-scan counters, box counter and pending-clear flag.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        box_d   = box_q;
        pend_d  = pend_q;
        ovr_d   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                pend_d = 1'b0;
                box_d  = '0;
                if (addr_q == ADDR_LAST) begin
                    state_d = S_IDLE;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + XY_W'(1);
                    end else begin
                        x_d = x_q + XY_W'(1);
                    end
                end
            end
            S_IDLE: begin
                if (bus.start) state_d = S_START_WAIT;
            end
            S_START_WAIT: begin
                if (!bus.start) state_d = S_WAIT_BEAT;
            end
            S_WAIT_BEAT: begin
                if (abort_ev) begin
                    state_d = S_CLEAR;
                    pend_d  = 1'b0;
                end else if (bus.beat_tick && !bus.pause) begin
                    state_d = S_ISSUE;
                    box_d   = '0;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_SHAPE;
                ovr_d   = bus.beat_tick;
                pend_d  = pend_q | abort_ev;
            end
            S_WAIT_SHAPE: begin
                ovr_d  = bus.beat_tick;
                pend_d = pend_q | abort_ev;
                if (bus.shape_done) begin
                    if (box_q == BOX_LAST) begin
                        // An abort arriving with the final shape_done still counts.
                        box_d   = '0;
                        state_d = (pend_q | abort_ev) ? S_CLEAR : S_WAIT_BEAT;
                        pend_d  = 1'b0;
                    end else begin
                        box_d   = box_q + BOX_W'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
                x_d     = '0;
                y_d     = '0;
                addr_d  = '0;
                box_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset into a fresh grid clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_CLEAR;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            box_q   <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            box_q   <= box_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.clear_we       = (state_q == S_CLEAR);
    assign bus.clear_addr     = addr_q;
    assign bus.clear_x        = x_q;
    assign bus.clear_y        = y_q;
    assign bus.shape_start    = (state_q == S_ISSUE);
    assign bus.box_index      = box_q;
    assign bus.ready_for_song = (state_q == S_WAIT_BEAT);
    assign bus.busy           = (state_q == S_CLEAR) || (state_q == S_ISSUE) ||
                                (state_q == S_WAIT_SHAPE);
    assign bus.beat_overrun   = ovr_q;
    assign bus.state          = state_q;

endmodule

// File: tb/tb_lane_draw_sequencer.sv
// Directed bench for the lane draw sequencer on a 4x3 grid with 3 boxes.
// Clear writes, shape_start pulses and overrun pulses are checked by a
// negedge monitor against queues filled when the stimulus is driven.
module tb_lane_draw_sequencer;
    localparam int GW = 4;
    localparam int GH = 3;
    localparam int NB = 3;

    typedef struct packed {
        logic [3:0] addr;
        logic [1:0] x;
        logic [1:0] y;
    } clr_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    clr_t clr_q[$];
    int   box_q[$];
    int   ovr_q[$];

    lane_draw_sequencer_if #(.XY_W(2), .ADDR_W(4), .BOX_W(2)) bus ();

    lane_draw_sequencer #(
        .GRID_W(GW), .GRID_H(GH), .NUM_BOXES(NB),
        .XY_W(2), .ADDR_W(4), .BOX_W(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_clear();
        for (int a = 0; a < GW * GH; a++) begin
            clr_t e;
            e.addr = 4'(a);
            e.x    = 2'(a % GW);
            e.y    = 2'(a / GW);
            clr_q.push_back(e);
        end
    endtask

    task automatic wait_state(input logic [2:0] tgt, output int n);
        n = 0;
        while (bus.state !== tgt && n < 40) begin
            tick();
            n++;
        end
        chk("wait_state_reached", {29'd0, bus.state}, {29'd0, tgt});
    endtask

    // Answers each shape_start with shape_done three cycles later; optionally
    // injects a beat or a song_done one cycle into the given box.
    task automatic serve(input int n, input int beat_at, input int song_at);
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (bus.shape_start !== 1'b1 && w < 20) begin
                tick();
                w++;
            end
            chk("shape_start_seen", {31'd0, bus.shape_start}, 32'd1);
            tick();
            if (i == beat_at) begin
                bus.beat_tick = 1'b1;
                ovr_q.push_back(1);
            end
            if (i == song_at) begin
                bus.song_done = 1'b1;
                push_clear();
            end
            tick();
            bus.beat_tick = 1'b0;
            bus.song_done = 1'b0;
            tick();
            bus.shape_done = 1'b1;
            tick();
            bus.shape_done = 1'b0;
        end
    endtask

    task automatic press_start();
        bus.start = 1'b1;
        tick();
        chk("state_start_wait", {29'd0, bus.state}, 32'd2);
        tick();
        bus.start = 1'b0;
        tick();
        chk("state_wait_beat", {29'd0, bus.state}, 32'd3);
    endtask

    task automatic beat();
        for (int b = 0; b < NB; b++) box_q.push_back(b);
        bus.beat_tick = 1'b1;
        tick();
        bus.beat_tick = 1'b0;
    endtask

    // Scoreboard monitor: every DUT output event must match a queued expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.clear_we) begin
                clr_t got, exp;
                logic has;
                got = {bus.clear_addr, bus.clear_x, bus.clear_y};
                has = (clr_q.size() != 0);
                exp = has ? clr_q.pop_front() : '0;
                checks++;
                assert (has && got === exp) else begin
                    errors++;
                    $error("FAIL clear_write: observed %0h expected %0h (queued %0d)", got, exp, has);
                end
            end
            if (bus.shape_start) begin
                int eb;
                logic has;
                has = (box_q.size() != 0);
                eb  = has ? box_q.pop_front() : -1;
                checks++;
                assert (has && bus.box_index === 2'(eb)) else begin
                    errors++;
                    $error("FAIL shape_box: observed %0d expected %0d", bus.box_index, eb);
                end
            end
            if (bus.beat_overrun) begin
                logic has;
                has = (ovr_q.size() != 0);
                if (has) void'(ovr_q.pop_front());
                checks++;
                assert (has) else begin
                    errors++;
                    $error("FAIL overrun_pulse: observed unexpected pulse expected none");
                end
            end
        end
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.beat_tick = 1'b0;
        bus.song_done = 1'b0;
        bus.pause = 1'b0;
        bus.clear_req = 1'b0;
        bus.shape_done = 1'b0;

        tick();
        tick();
        chk("reset_state", {29'd0, bus.state}, 32'd0);
        chk("reset_box", {30'd0, bus.box_index}, 32'd0);
        chk("reset_overrun", {31'd0, bus.beat_overrun}, 32'd0);
        chk("reset_addr", {28'd0, bus.clear_addr}, 32'd0);

        push_clear();
        reset = 1'b0;
        wait_state(3'd1, n);
        chk("first_clear_len", n, 32'd12);
        chk("idle_addr_held", {28'd0, bus.clear_addr}, 32'd0);
        chk("idle_we_low", {31'd0, bus.clear_we}, 32'd0);

        bus.song_done = 1'b1;
        tick();
        bus.song_done = 1'b0;
        tick();
        chk("idle_ignores_song_done", {29'd0, bus.state}, 32'd1);

        press_start();
        chk("ready_for_song", {31'd0, bus.ready_for_song}, 32'd1);
        chk("not_busy_wait_beat", {31'd0, bus.busy}, 32'd0);

        beat();
        chk("busy_in_issue", {31'd0, bus.busy}, 32'd1);
        serve(3, -1, -1);
        chk("seq_end_state", {29'd0, bus.state}, 32'd3);
        chk("seq_end_box", {30'd0, bus.box_index}, 32'd0);

        bus.pause = 1'b1;
        bus.beat_tick = 1'b1;
        tick();
        bus.beat_tick = 1'b0;
        tick();
        bus.pause = 1'b0;
        chk("pause_ignores_beat", {29'd0, bus.state}, 32'd3);

        beat();
        serve(3, 1, -1);
        tick();
        chk("overrun_seq_end_state", {29'd0, bus.state}, 32'd3);

        beat();
        serve(3, -1, 1);
        chk("song_done_to_clear", {29'd0, bus.state}, 32'd0);
        wait_state(3'd1, n);
        chk("song_clear_len", n, 32'd12);

        press_start();
        bus.clear_req = 1'b1;
        push_clear();
        tick();
        bus.clear_req = 1'b0;
        chk("clear_req_to_clear", {29'd0, bus.state}, 32'd0);
        wait_state(3'd1, n);
        chk("req_clear_len", n, 32'd12);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 5; a++) begin
            clr_t e;
            e.addr = 4'(a);
            e.x    = 2'(a % GW);
            e.y    = 2'(a / GW);
            clr_q.push_back(e);
        end
        for (int k = 0; k < 5; k++) tick();
        chk("mid_clear_addr5", {28'd0, bus.clear_addr}, 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push_clear();
        chk("restart_addr0", {28'd0, bus.clear_addr}, 32'd0);
        chk("restart_state", {29'd0, bus.state}, 32'd0);
        wait_state(3'd1, n);
        chk("restart_clear_len", n, 32'd12);

        tick();
        chk("clear_queue_drained", clr_q.size(), 32'd0);
        chk("box_queue_drained", box_q.size(), 32'd0);
        chk("overrun_queue_drained", ovr_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lane_draw_sequencer.md
LANE_DRAW_SEQUENCER -- requirements
Module: lane_draw_sequencer

Interface
REQ-001 Parameter GRID_W, 240, grid width in pixels (>=2).
REQ-002 Parameter GRID_H, 180, grid height in pixels (>=2).
REQ-003 Parameter NUM_BOXES, 12, note boxes drawn per beat (>=1).
REQ-004 Parameter XY_W, 8, width of x/y coordinates; SHALL hold GRID_W-1 and GRID_H-1.
REQ-005 Parameter ADDR_W, 16, linear address width; SHALL hold GRID_W*GRID_H-1.
REQ-006 Parameter BOX_W, 4, box index width; SHALL hold NUM_BOXES-1.
REQ-007 clock  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  player start button, level.
REQ-010 beat_tick  in  1  one-cycle pulse, new beat.
REQ-011 song_done  in  1  one-cycle pulse, song finished.
REQ-012 pause  in  1  level; while high, beats are ignored.
REQ-013 clear_req  in  1  one-cycle pulse, request grid clear.
REQ-014 shape_done  in  1  one-cycle pulse from shape drawer.
REQ-015 clear_we  out  1  write strobe for default pixel.
REQ-016 clear_addr  out  ADDR_W  row-major pixel address, y*GRID_W+x.
REQ-017 clear_x, clear_y  out  XY_W each  pixel coordinates.
REQ-018 shape_start  out  1  one-cycle pulse: draw box box_index.
REQ-019 box_index  out  BOX_W  current box.
REQ-020 ready_for_song  out  1  high in WAIT_BEAT.
REQ-021 busy  out  1  high in CLEAR, ISSUE, WAIT_SHAPE.
REQ-022 beat_overrun  out  1  one-cycle pulse, beat dropped.
REQ-023 state  out  3  encoded state: CLEAR=0, IDLE=1, START_WAIT=2, WAIT_BEAT=3, ISSUE=4, WAIT_SHAPE=5.

Function
REQ-024 CLEAR: clear_we=1 every cycle; x increments; at x=GRID_W-1, x->0 and y increments; addr increments by 1 every cycle.
REQ-025 CLEAR SHALL last exactly GRID_W*GRID_H cycles; after the write of (GRID_W-1, GRID_H-1) at addr GRID_W*GRID_H-1, go to IDLE; x, y, addr return to 0.
REQ-026 Outside CLEAR, clear_we=0 and x, y, addr are held at 0.
REQ-027 IDLE: start=1 -> START_WAIT; START_WAIT: start=0 -> WAIT_BEAT (press-and-release).
REQ-028 WAIT_BEAT priority: song_done -> CLEAR; else clear_req -> CLEAR; else beat_tick & !pause -> ISSUE with box_index=0; else stay.
REQ-029 beat_tick while pause=1 in WAIT_BEAT SHALL be ignored silently (no overrun).
REQ-030 ISSUE: shape_start=1 for exactly one cycle, then WAIT_SHAPE.
REQ-031 WAIT_SHAPE: shape_done with box_index<NUM_BOXES-1 -> box_index+1, ISSUE; with box_index=NUM_BOXES-1 -> WAIT_BEAT.
REQ-032 shape_done outside WAIT_SHAPE SHALL be ignored.
REQ-033 beat_tick in ISSUE or WAIT_SHAPE SHALL pulse beat_overrun the following cycle and be dropped.
REQ-034 song_done or clear_req in ISSUE/WAIT_SHAPE SHALL set a pending flag; once the box sequence ends, go to CLEAR instead of WAIT_BEAT; the flag is cleared on CLEAR entry.
REQ-035 song_done/clear_req in CLEAR, IDLE or START_WAIT SHALL be ignored.
REQ-036 box_index SHALL hold its value in WAIT_SHAPE and be 0 in all states except ISSUE/WAIT_SHAPE.

Reset
REQ-037 reset=1 at a clock edge, from any state: state=CLEAR, x=y=addr=0, box_index=0, pending flag=0, shape_start=0, beat_overrun=0.
REQ-038 First cycle after reset deasserts: clear_we=1, addr=0; a mid-clear reset restarts the clear from addr 0.

Verification (GRID_W=4, GRID_H=3, NUM_BOXES=3)
REQ-039 Release reset -> clear_we high 12 cycles, addr 0..11, (x,y) ends at (3,2), then state=1.
REQ-040 start high 2 cycles then low -> state 1->2->3, ready_for_song=1.
REQ-041 beat_tick, shape_done 3 cycles after each shape_start -> shape_start pulses with box_index 0,1,2, then state=3.
REQ-042 beat_tick during WAIT_SHAPE -> beat_overrun single pulse, sequence unchanged; beat_tick with pause=1 -> no ISSUE, no overrun.
REQ-043 song_done during box 1 -> boxes 1,2 complete, then CLEAR 12 cycles, then IDLE.
REQ-044 reset at addr 5 of CLEAR -> next cycle addr=0, full 12-cycle clear.
